// File: rtl/div_sequencer_if.sv
// ============================================================================
// Module : div_sequencer_if
// Brief  : Control/data bundle between div_sequencer and the restoring divider
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface div_sequencer_if;
    logic [5:0]  div_signal;
    logic [31:0] div_dataA;
    logic [31:0] div_dataB;
    logic        div_reset;
    logic [63:0] div_result;

    modport master (
        output div_signal,
        output div_dataA,
        output div_dataB,
        output div_reset,
        input  div_result
    );

    modport slave (
        input  div_signal,
        input  div_dataA,
        input  div_dataB,
        input  div_reset,
        output div_result
    );
endinterface

`default_nettype wire

// File: rtl/div_sequencer.sv
// ============================================================================
// Module : div_sequencer
// Brief  : EX-stage DIVU sequencer with HI/LO registers; DIV_ZERO_FAST_EN
//          enables the divide-by-zero shortcut and sticky div_zero flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_sequencer #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter logic [5:0]  FUNCT_DIVU = 6'b011011,
    parameter logic [5:0]  IDLE_CODE  = 6'b111111
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [5:0]             funct,
    input  logic [31:0]            rs_data,
    input  logic [31:0]            rt_data,
    input  logic                   flush,
    input  logic                   hi_we,
    input  logic                   lo_we,
    input  logic [31:0]            wdata,
    input  logic                   rd_sel,
    output logic [31:0]            rd_data,
    div_sequencer_if.master        div_bus,
    output logic [31:0]            hi,
    output logic [31:0]            lo,
    output logic                   busy,
    output logic                   stall,
    output logic                   done,
    output logic                   div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] div_a_q;
    logic [31:0] div_b_q;
    logic        div_reset_q;
    logic        busy_q;
    logic        done_q;
`ifdef DIV_ZERO_FAST_EN
    logic        fast_q;
    logic        dz_q;
`endif

    logic w_is_divu;
    logic w_start_div;

    assign w_is_divu   = start && (funct == FUNCT_DIVU);
    // A same-cycle flush kills the issuing divide, but stall still follows the raw request.
    assign w_start_div = w_is_divu && !flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 6'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            div_a_q     <= 32'd0;
            div_b_q     <= 32'd0;
            div_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
            fast_q      <= 1'b0;
            dz_q        <= 1'b0;
`endif
        end else begin
            div_reset_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (hi_we) hi_q <= wdata;
                    if (lo_we) lo_q <= wdata;
                    if (w_start_div) begin
                        div_a_q <= rs_data;
                        div_b_q <= rt_data;
                        busy_q  <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                        if (rt_data == 32'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            fast_q  <= 1'b1;
                            dz_q    <= 1'b1;
                        end else begin
                            state_q <= S_LOAD;
                        end
`else
                        state_q <= S_LOAD;
`endif
                    end
                end
                S_LOAD: begin
                    cnt_q <= 6'd0;
                    if (flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == 6'(DIV_CYCLES - 1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
`ifdef DIV_ZERO_FAST_EN
                    if (fast_q) begin
                        hi_q <= div_a_q;
                        lo_q <= 32'hFFFF_FFFF;
                    end else begin
                        hi_q <= div_bus.div_result[63:32];
                        lo_q <= div_bus.div_result[31:0];
                    end
                    fast_q <= 1'b0;
`else
                    hi_q <= div_bus.div_result[63:32];
                    lo_q <= div_bus.div_result[31:0];
`endif
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign div_bus.div_signal = (state_q == S_RUN) ? FUNCT_DIVU : IDLE_CODE;
    assign div_bus.div_dataA  = div_a_q;
    assign div_bus.div_dataB  = div_b_q;
    assign div_bus.div_reset  = div_reset_q;

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign rd_data = rd_sel ? hi_q : lo_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign stall   = busy_q | ((state_q == S_IDLE) & w_is_divu);
`ifdef DIV_ZERO_FAST_EN
    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Controls the 32-iteration restoring unsigned divider in the EX stage.
- Latches operands, drives the divider's control code for one load cycle and then 32 iteration cycles, and stalls the pipeline while the divide runs.
- Commits the divider's {remainder, quotient} output into the architectural HI/LO registers.
- Also services MTHI/MTLO writes and MFHI/MFLO reads.

Parameters:
- DIV_CYCLES, 32, number of divider iteration cycles (Signal = FUNCT_DIVU).
- FUNCT_DIVU, 6'b011011, funct code that starts a divide and divider iterate code.
- IDLE_CODE, 6'b111111, divider code for load/hold (any non-DIVU value loads operands).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  EX-stage instruction valid
- funct  in  6  EX-stage funct field
- rs_data  in  32  dividend
- rt_data  in  32  divisor
- flush  in  1  abort in-flight divide (branch/exception)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  32  MTHI/MTLO data
- rd_sel  in  1  0 = read LO, 1 = read HI
- rd_data  out  32  combinational HI/LO read
- div_signal  out  6  to divider Signal
- div_dataA  out  32  to divider dataA (registered)
- div_dataB  out  32  to divider dataB (registered)
- div_reset  out  1  to divider reset (active-high, registered)
- div_result  in  64  from divider dataOut: [63:32] remainder, [31:0] quotient
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  divide in progress
- stall  out  1  pipeline freeze request
- done  out  1  high during the commit cycle
- div_zero  out  1  sticky divide-by-zero flag (optional feature)

Behaviour:
- States: IDLE, LOAD, RUN, DONE. The state register and iteration counter cnt[5:0] are registered.
- Reset (reset_n low, asynchronous):
  - state = IDLE, cnt = 0, hi = lo = 0.
  - div_dataA = div_dataB = 0, div_reset = 1, div_zero = 0.
  - busy = done = 0.
- div_reset deasserts to 0 on the first rising edge after reset_n rises, and stays 0 thereafter.
- IDLE:
  - div_signal = IDLE_CODE.
  - If start && funct == FUNCT_DIVU: latch div_dataA = rs_data and div_dataB = rt_data, then go to LOAD.
- LOAD (1 cycle):
  - div_signal = IDLE_CODE; the divider loads its operands at the end of this cycle.
  - cnt <= 0; next state RUN.
- RUN:
  - div_signal = FUNCT_DIVU; cnt increments each cycle.
  - When cnt == DIV_CYCLES-1, go to DONE.
- DONE (1 cycle):
  - div_signal = IDLE_CODE, done = 1.
  - At the edge: hi <= div_result[63:32], lo <= div_result[31:0]; then go to IDLE.
- Latency: with start sampled at edge E0, HI/LO hold the new value after edge E0+34.
- busy = (state != IDLE), high for 34 cycles.
- stall = busy | (state == IDLE & start & funct == FUNCT_DIVU). It is combinational, so the issuing instruction freezes in its own cycle.
- start while busy: ignored, because the pipeline is already stalled.
- Non-DIVU funct in IDLE: no action.
- flush:
  - In LOAD or RUN: go to IDLE next edge. HI/LO unchanged, done never asserts.
  - In DONE: ignored; the commit completes.
  - In IDLE: suppresses a same-cycle start.
- MTHI/MTLO:
  - In IDLE: hi_we/lo_we write wdata at the edge.
  - While busy: ignored.
  - hi_we together with start in IDLE: the write applies and the divide starts. The divide's later commit overwrites it.
- rd_data is a pure mux of hi/lo, with no bypass from DONE.
- Arithmetic is unsigned only. Divisor 0 yields LO = 32'hFFFFFFFF and HI = dividend (the inherent restoring-algorithm result).
- reset_n asserted mid-divide: immediate return to IDLE with all reset values, and div_reset = 1 clears the divider.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined:
  - In IDLE, a DIVU start with rt_data == 0 goes straight to DONE, with busy for 1 cycle.
  - The commit writes hi = rs_data and lo = 32'hFFFFFFFF from latched values; the divider is not run.
  - div_zero is set sticky; it clears only on reset.
- Undefined:
  - Divide-by-zero runs the full 34-cycle path with the same HI/LO result.
  - div_zero is tied to 0.

Test Plan:
- Reset, then start with DIVU, rs = 100, rt = 7:
  - stall high in the start cycle; busy high for 34 cycles; done pulses once.
  - Then lo = 14, hi = 2; rd_sel = 0 gives 14.
- DIVU with rs = 32'hFFFFFFFF, rt = 1: lo = 32'hFFFFFFFF, hi = 0 after 34 cycles. Back-to-back second DIVU with rs = 7, rt = 9: lo = 0, hi = 7.
- DIVU with rs = 5, rt = 0: hi = 5, lo = 32'hFFFFFFFF.
  - With DIV_ZERO_FAST_EN defined: busy 1 cycle, div_zero = 1.
  - With it undefined: busy 34 cycles, div_zero = 0.
- Preload lo = 32'h1234 via lo_we; DIVU with rs = 50, rt = 3; assert flush at cycle 10 of RUN:
  - busy drops next edge; lo stays 32'h1234; done never asserts.
- reset_n low at RUN cycle 20, asynchronously mid-cycle:
  - busy, hi, lo immediately 0; div_reset = 1.
  - After release, DIVU with rs = 9, rt = 4 gives lo = 2, hi = 1.
- hi_we with wdata = 32'hAAAA while busy is ignored (hi keeps its value). The same write in IDLE makes hi = 32'hAAAA the next cycle.
